// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage and its IF/ID register.
//   word_t        : 32-bit instruction word / byte address
//   fetch_state_e : fetch FSM states
//   NOP_INSTR     : bubble instruction loaded into IF/ID
//   pc_inc        : sequential next-PC (modulo 2^32)
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t NOP_INSTR = 32'h0;

    // REQ: request outstanding, HOLD: returned word buffered under stall,
    // DROP: redirect arrived before ack, return will be discarded.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    function automatic word_t pc_inc(input word_t pc);
        return pc + word_t'(4);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port.
//   imem_req   : fetch request, held with stable imem_addr until imem_ack
//   imem_addr  : fetch address
//   imem_ack   : imem_rdata valid this cycle (may coincide with the request)
//   imem_rdata : fetched instruction
// master = fetch stage side, slave = memory side.
interface fetch_stage_if;

    logic          imem_req;
    cpu_pkg::word_t imem_addr;
    logic          imem_ack;
    cpu_pkg::word_t imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with write-enable and synchronous bubble load.
//   clk, rst_n    : clock, synchronous active-low reset
//   load_i        : capture instr_i/pc_plus4_i as a valid instruction
//   bubble_i      : load a NOP bubble (takes priority over load_i)
//   instr_i       : instruction to capture
//   pc_plus4_i    : address of instr_i + 4
//   instr_o, pc_plus4_o, valid_o : registered IF/ID contents
module if_id_reg
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_i,
    input  logic  bubble_i,
    input  word_t instr_i,
    input  word_t pc_plus4_i,
    output word_t instr_o,
    output word_t pc_plus4_o,
    output logic  valid_o
);

    word_t instr_q;
    word_t pc_plus4_q;
    logic  valid_q;

    // IF/ID storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (bubble_i) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (load_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory port and
// loads IF/ID, honouring hazard-unit stalls and ID-stage redirects without
// losing or duplicating instructions.
//   clk, rst_n     : clock, synchronous active-low reset
//   pc_write       : PC update enable (hazard unit PCWrite)
//   if_id_write    : IF/ID write enable (hazard unit IF_ID_Write)
//   flush          : taken branch/jump resolved in ID this cycle
//   redirect_pc    : target address, valid with flush
//   imem           : instruction-memory port (master)
//   if_id_instr    : IF/ID instruction (NOP when bubble)
//   if_id_pc_plus4 : address of if_id_instr + 4
//   if_id_valid    : IF/ID holds a real instruction
//   fetch_busy     : request outstanding and not acknowledged this cycle
module fetch_stage
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pc_write,
    input  logic          if_id_write,
    input  logic          flush,
    input  word_t         redirect_pc,
    fetch_stage_if.master imem,
    output word_t         if_id_instr,
    output word_t         if_id_pc_plus4,
    output logic          if_id_valid,
    output logic          fetch_busy
);

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        buf_q, buf_d;
    word_t        pend_q, pend_d;

    logic  advance;
    logic  flush_eff;
    logic  ack;
    logic  ifid_load;
    logic  ifid_bubble;
    word_t ifid_instr;
    word_t pc_plus4;

    // A stalled ID stage has not resolved its branch, so flush needs if_id_write.
    assign advance   = pc_write & if_id_write;
    assign flush_eff = flush & if_id_write;
    assign ack       = imem.imem_ack;
    assign pc_plus4  = pc_inc(pc_q);

    // Next-state, PC, buffer and IF/ID control
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_d       = buf_q;
        pend_d      = pend_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_instr  = imem.imem_rdata;

        case (state_q)
            REQ: begin
                if (flush_eff) begin
                    ifid_bubble = 1'b1;
                    if (ack) begin
                        pc_d = redirect_pc;
                    end else begin
                        // Address must stay stable until ack; remember target.
                        pend_d  = redirect_pc;
                        state_d = DROP;
                    end
                end else if (ack) begin
                    if (advance) begin
                        ifid_load = 1'b1;
                        pc_d      = pc_plus4;
                    end else begin
                        buf_d   = imem.imem_rdata;
                        state_d = HOLD;
                    end
                end else if (if_id_write) begin
                    ifid_bubble = 1'b1;
                end
            end

            HOLD: begin
                if (flush_eff) begin
                    ifid_bubble = 1'b1;
                    pc_d        = redirect_pc;
                    state_d     = REQ;
                end else if (advance) begin
                    ifid_load  = 1'b1;
                    ifid_instr = buf_q;
                    pc_d       = pc_plus4;
                    state_d    = REQ;
                end
            end

            DROP: begin
                ifid_bubble = if_id_write;
                if (flush_eff) begin
                    pend_d = redirect_pc;
                end
                if (ack) begin
                    // Latest target wins, including one arriving with the ack.
                    pc_d    = flush_eff ? redirect_pc : pend_q;
                    state_d = REQ;
                end
            end

            default: begin
                state_d = REQ;
            end
        endcase
    end

    // State, PC, buffer and pending-target registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
        end
    end

    assign imem.imem_req  = rst_n & (state_q != HOLD);
    assign imem.imem_addr = pc_q;
    assign fetch_busy     = imem.imem_req & ~imem.imem_ack;

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ifid_load),
        .bubble_i   (ifid_bubble),
        .instr_i    (ifid_instr),
        .pc_plus4_i (pc_plus4),
        .instr_o    (if_id_instr),
        .pc_plus4_o (if_id_pc_plus4),
        .valid_o    (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stalls/flushes/resets/latencies, compared against a behavioural model.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  pc_write;
    logic  if_id_write;
    logic  flush;
    word_t redirect_pc;
    word_t if_id_instr;
    word_t if_id_pc_plus4;
    logic  if_id_valid;
    logic  fetch_busy;

    fetch_stage_if imem_bus ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_busy     (fetch_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory behaviour: fixed or random (-1) wait cycles per request
    int wait_left = 0;
    int lat_cfg   = 0;

    // Reference model: fetch pointer, buffered word, pending discard
    word_t m_pc, m_buf, m_pend, m_instr, m_pp4;
    bit    m_held, m_discard, m_valid;

    function automatic word_t mem_data(input word_t a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_bubble();
        m_instr = NOP_INSTR;
        m_pp4   = '0;
        m_valid = 1'b0;
    endtask

    task automatic m_load(input word_t instr);
        m_instr = instr;
        m_pp4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
    endtask

    task automatic model_update(input bit r, input bit pw, input bit iw,
                                input bit fl, input word_t rpc, input bit ack);
        bit adv;
        bit ef;
        adv = pw && iw;
        ef  = fl && iw;
        if (!r) begin
            m_pc = 32'h0; m_buf = '0; m_pend = '0;
            m_held = 1'b0; m_discard = 1'b0;
            m_bubble();
        end else if (m_held) begin
            if (ef) begin
                m_bubble(); m_pc = rpc; m_held = 1'b0;
            end else if (adv) begin
                m_load(m_buf); m_held = 1'b0;
            end
        end else if (m_discard) begin
            if (ef) m_pend = rpc;
            if (iw) m_bubble();
            if (ack) begin
                m_pc = m_pend; m_discard = 1'b0;
            end
        end else if (ef) begin
            m_bubble();
            if (ack) m_pc = rpc;
            else begin
                m_discard = 1'b1; m_pend = rpc;
            end
        end else if (ack) begin
            if (adv) m_load(mem_data(m_pc));
            else begin
                m_held = 1'b1; m_buf = mem_data(m_pc);
            end
        end else if (iw) begin
            m_bubble();
        end
    endtask

    // One clock: drive at negedge, check port decode, clock, check IF/ID.
    task automatic step(input bit r, input bit pw, input bit iw,
                        input bit fl, input word_t rpc);
        bit ack;
        bit req_exp;
        @(negedge clk);
        rst_n       = r;
        pc_write    = pw;
        if_id_write = iw;
        flush       = fl;
        redirect_pc = rpc;
        #1;
        ack = 1'b0;
        if (r && imem_bus.imem_req === 1'b1) begin
            if (wait_left == 0) ack = 1'b1;
            else wait_left--;
        end
        imem_bus.imem_ack   = ack;
        imem_bus.imem_rdata = ack ? mem_data(imem_bus.imem_addr) : 32'hDEAD_BEEF;
        #1;
        req_exp = r && !m_held;
        chk("imem_req", word_t'(imem_bus.imem_req), word_t'(req_exp));
        chk("fetch_busy", word_t'(fetch_busy), word_t'(req_exp && !ack));
        if (r) chk("imem_addr", imem_bus.imem_addr, m_pc);
        @(posedge clk);
        model_update(r, pw, iw, fl, rpc, ack);
        if (!r || ack) wait_left = (lat_cfg < 0) ? int'($urandom_range(0, 2)) : lat_cfg;
        #1;
        chk("if_id_valid", word_t'(if_id_valid), word_t'(m_valid));
        chk("if_id_instr", if_id_instr, m_instr);
        if (m_valid) chk("if_id_pc_plus4", if_id_pc_plus4, m_pp4);
    endtask

    // Return to zero-wait memory with no request in progress
    task automatic drain();
        lat_cfg = 0;
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    endtask

    initial begin
        rst_n = 1'b0; pc_write = 1'b0; if_id_write = 1'b0; flush = 1'b0;
        redirect_pc = '0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
        m_pc = '0; m_buf = '0; m_pend = '0; m_instr = '0; m_pp4 = '0;
        m_held = 1'b0; m_discard = 1'b0; m_valid = 1'b0;

        // Reset; an ack would be ignored here
        lat_cfg = 0;
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        chk("rst_pc_plus4", if_id_pc_plus4, 32'h0);
        chk("rst_valid", word_t'(if_id_valid), 32'h0);

        // Zero-wait streaming
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, '0);
            chk("seq_pc_plus4", if_id_pc_plus4, word_t'(4 * k));
            chk("seq_valid", word_t'(if_id_valid), 32'h1);
        end

        // 2-cycle memory latency
        lat_cfg = 1;
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, '0);

        // Stall 3 cycles with ack in the first, then release
        drain();
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("hold_req", word_t'(imem_bus.imem_req), 32'h0);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, '0);

        // Flush with ack in the same cycle
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
        chk("flush_addr", imem_bus.imem_addr, 32'h100);
        chk("flush_bubble", word_t'(if_id_valid), 32'h0);

        // Flush during a wait: discard, then refetch target
        lat_cfg = 2;
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("drop_addr", imem_bus.imem_addr, 32'h100);

        // Flush while if_id_write=0 is ignored
        drain();
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h500);
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h500);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);

        // Two flushes in DROP: latest target wins
        drain();
        lat_cfg = 3;
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("drop2_addr", imem_bus.imem_addr, 32'h300);

        // Reset mid-HOLD
        drain();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);

        // Reset mid-DROP
        lat_cfg = 2;
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h400);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        chk("rst_drop_valid", word_t'(if_id_valid), 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);

        // PC wrap
        drain();
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("wrap_pc_plus4", if_id_pc_plus4, 32'h0);
        chk("wrap_addr", imem_bus.imem_addr, 32'h0);

        // Random traffic
        lat_cfg = -1;
        for (int i = 0; i < 400; i++) begin
            bit r, pw, iw, fl;
            word_t rpc;
            r   = ($urandom_range(0, 99) >= 2);
            pw  = ($urandom_range(0, 9) >= 2);
            iw  = ($urandom_range(0, 9) >= 2);
            fl  = ($urandom_range(0, 9) == 0);
            rpc = {$urandom(), 2'b00} >> 0;
            rpc[1:0] = 2'b00;
            step(r, pw, iw, fl, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
